// File: rtl/lizard_collision.sv
// Lizard wall/ledge probe and player overlap test, run once per frame tick.
// Optional LIZARD_LEDGE_TURN_EN adds a ground probe so the lizard turns at ledges.
module lizard_collision #(
    parameter int LIZ_W        = 32,
    parameter int LIZ_H        = 32,
    parameter int PLAYER_W     = 32,
    parameter int PLAYER_H     = 32,
    parameter int STOMP_MARGIN = 8,
    parameter int MAP_COLS     = 20,
    parameter int MAP_ROWS     = 15
) (
    input  logic        sim_clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [31:0] lizardState,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    input  logic        player_falling,
    output logic [8:0]  tile_addr,
    input  logic        tile_solid,
    output logic [1:0]  lizardCol,
    output logic        lizardKillCol,
    output logic        player_hit,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, Q_TOP, Q_BOT, Q_GND, EVAL, DONE} state_t;

    function automatic logic [5:0] clamp_row(input logic [5:0] r);
        return (r >= 6'(MAP_ROWS)) ? 6'(MAP_ROWS - 1) : r;
    endfunction

    function automatic logic [5:0] clamp_col(input logic [5:0] c);
        return (c >= 6'(MAP_COLS)) ? 6'(MAP_COLS - 1) : c;
    endfunction

    function automatic logic [8:0] addr_of(input logic [5:0] r, input logic [5:0] c);
        return 9'(r * MAP_COLS + c);
    endfunction

    logic [10:0] w_x, w_y, w_spd, w_px, w_py, w_lx;
    logic        w_dir, w_offmap, w_ov, w_stomp, w_dead;
    logic [5:0]  w_col, w_rt, w_rb;
    logic        w_unused;

    assign w_x   = {1'b0, lizardState[31:22]};
    assign w_y   = {1'b0, lizardState[21:12]};
    assign w_spd = {6'b0, lizardState[11:7]};
    assign w_dir = lizardState[1];
    assign w_px  = {1'b0, player_x};
    assign w_py  = {1'b0, player_y};
    assign w_unused = ^{lizardState[6:2], lizardState[0]};

    assign w_lx = w_dir ? (w_x + w_spd + 11'(LIZ_W - 1)) : (w_x - w_spd);
    assign w_offmap = (!w_dir && (w_x < w_spd)) || (w_lx >= 11'(MAP_COLS * 32));
    assign w_col = clamp_col(6'(w_lx >> 5));
    assign w_rt  = clamp_row(6'(w_y >> 5));
    assign w_rb  = clamp_row(6'((w_y + 11'(LIZ_H - 1)) >> 5));

    // Strict overlap on both axes; 11-bit sums cannot wrap for 10-bit positions.
    assign w_ov = (w_px < w_x + 11'(LIZ_W)) && (w_px + 11'(PLAYER_W) > w_x) &&
                  (w_py < w_y + 11'(LIZ_H)) && (w_py + 11'(PLAYER_H) > w_y);
    assign w_stomp = w_ov && player_falling &&
                     (w_py + 11'(PLAYER_H - 1) < w_y + 11'(STOMP_MARGIN));

    logic r_killed;
    assign w_dead = r_killed || (w_spd == 11'd0);

    state_t     r_state;
    logic       r_wall, r_dir, r_kill_p, r_hit_p, r_dead;
    logic [8:0] r_addr_bot;
`ifdef LIZARD_LEDGE_TURN_EN
    logic [8:0] r_addr_gnd;
    logic       r_gnd_off;
    logic [5:0] w_rg_raw;
    assign w_rg_raw = 6'((w_y + 11'(LIZ_H)) >> 5);
`endif

    always_ff @(posedge sim_clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_wall        <= 1'b0;
            r_dir         <= 1'b0;
            r_kill_p      <= 1'b0;
            r_hit_p       <= 1'b0;
            r_dead        <= 1'b0;
            r_killed      <= 1'b0;
            r_addr_bot    <= '0;
`ifdef LIZARD_LEDGE_TURN_EN
            r_addr_gnd    <= '0;
            r_gnd_off     <= 1'b0;
`endif
            tile_addr     <= '0;
            lizardCol     <= 2'b00;
            lizardKillCol <= 1'b0;
            player_hit    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            lizardCol     <= 2'b00;
            lizardKillCol <= 1'b0;
            player_hit    <= 1'b0;
            case (r_state)
                IDLE: if (tick) begin
                    r_state    <= Q_TOP;
                    busy       <= 1'b1;
                    tile_addr  <= addr_of(w_rt, w_col);
                    r_addr_bot <= addr_of(w_rb, w_col);
                    // Off-map counts as solid; later ROM data can only OR into it.
                    r_wall     <= w_offmap;
                    r_dir      <= w_dir;
                    r_kill_p   <= w_stomp;
                    r_hit_p    <= w_ov && !w_stomp;
                    r_dead     <= w_dead;
`ifdef LIZARD_LEDGE_TURN_EN
                    r_addr_gnd <= addr_of(clamp_row(w_rg_raw), w_col);
                    r_gnd_off  <= (w_rg_raw >= 6'(MAP_ROWS));
`endif
                end
                Q_TOP: begin
                    r_state   <= Q_BOT;
                    tile_addr <= r_addr_bot;
                end
                Q_BOT: begin
                    r_wall <= r_wall | tile_solid;
`ifdef LIZARD_LEDGE_TURN_EN
                    r_state   <= Q_GND;
                    tile_addr <= r_addr_gnd;
`else
                    r_state   <= EVAL;
                    tile_addr <= '0;
`endif
                end
                Q_GND: begin
                    r_wall    <= r_wall | tile_solid;
                    r_state   <= EVAL;
                    tile_addr <= '0;
                end
                EVAL: begin
`ifdef LIZARD_LEDGE_TURN_EN
                    r_wall <= r_wall | (!tile_solid && !r_gnd_off);
`else
                    r_wall <= r_wall | tile_solid;
`endif
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    if (!r_dead) begin
                        lizardCol     <= r_dir ? {r_wall, 1'b0} : {1'b0, r_wall};
                        lizardKillCol <= r_kill_p;
                        player_hit    <= r_hit_p;
                        if (r_kill_p) r_killed <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lizard_collision.sv
// Directed bench for lizard_collision with a synchronous tile ROM model.
module tb_lizard_collision;

`ifdef LIZARD_LEDGE_TURN_EN
    localparam int         LAT     = 5;
    localparam logic [1:0] EMPTY_R = 2'b10;
    localparam logic [1:0] LEDGE_R = 2'b10;
`else
    localparam int         LAT     = 4;
    localparam logic [1:0] EMPTY_R = 2'b00;
    localparam logic [1:0] LEDGE_R = 2'b00;
`endif

    logic        sim_clk = 1'b0;
    logic        reset, tick, player_falling, tile_solid;
    logic [31:0] lizardState;
    logic [9:0]  player_x, player_y;
    logic [8:0]  tile_addr;
    logic [1:0]  lizardCol;
    logic        lizardKillCol, player_hit, busy;

    logic [299:0] map;
    logic [8:0]   a0, a1;
    int           n_chk = 0, n_pass = 0;

    always #5 sim_clk = ~sim_clk;

    always @(posedge sim_clk) tile_solid <= (tile_addr < 9'd300) ? map[tile_addr] : 1'b0;

    lizard_collision dut (
        .sim_clk(sim_clk), .reset(reset), .tick(tick), .lizardState(lizardState),
        .player_x(player_x), .player_y(player_y), .player_falling(player_falling),
        .tile_addr(tile_addr), .tile_solid(tile_solid), .lizardCol(lizardCol),
        .lizardKillCol(lizardKillCol), .player_hit(player_hit), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_liz(input int x, input int y, input int spd, input logic dir);
        lizardState = {10'(x), 10'(y), 5'(spd), 5'b0, dir, 1'b0};
    endtask

    task automatic set_ply(input int x, input int y, input logic f);
        player_x = 10'(x); player_y = 10'(y); player_falling = f;
    endtask

    task automatic do_reset();
        @(negedge sim_clk) reset = 1'b0;
        @(negedge sim_clk) reset = 1'b1;
    endtask

    task automatic scan(input string tag, input logic [1:0] ecol, input logic ekill, input logic ehit);
        logic bz;
        @(negedge sim_clk) tick = 1'b1;
        @(posedge sim_clk); #1 tick = 1'b0;
        bz = busy; a0 = tile_addr;
        for (int e = 1; e < LAT; e++) begin
            @(posedge sim_clk); #1;
            bz &= busy;
            if (e == 1) a1 = tile_addr;
        end
        @(posedge sim_clk); #1;
        chk({tag, "_col"}, 32'(lizardCol), 32'(ecol));
        chk({tag, "_kill"}, 32'(lizardKillCol), 32'(ekill));
        chk({tag, "_hit"}, 32'(player_hit), 32'(ehit));
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_busy_held"}, 32'(bz), 32'd1);
        @(posedge sim_clk); #1;
        chk({tag, "_after"}, 32'({lizardCol, lizardKillCol, player_hit}), 32'd0);
    endtask

    initial begin
        logic acc;
        reset = 1'b0; tick = 1'b0; map = '0;
        set_liz(200, 150, 3, 1'b1);
        set_ply(500, 400, 1'b0);
        repeat (2) @(posedge sim_clk);
        #1;
        chk("rst_out", 32'({lizardCol, lizardKillCol, player_hit, busy}), 32'd0);
        chk("rst_addr", 32'(tile_addr), 32'd0);
        @(negedge sim_clk) reset = 1'b1;

        // right wall at (row 4, col 7)
        map[87] = 1'b1;
        scan("right_wall", 2'b10, 1'b0, 1'b0);
        chk("rw_a0", 32'(a0), 32'd87);
        chk("rw_a1", 32'(a1), 32'd107);

        // left, solid at (row 5, col 3)
        map = '0; map[103] = 1'b1;
        set_liz(100, 150, 4, 1'b0);
        scan("left_wall", 2'b01, 1'b0, 1'b0);
        chk("lw_a0", 32'(a0), 32'd83);
        chk("lw_a1", 32'(a1), 32'd103);

        map = '0;
        set_liz(2, 150, 3, 1'b0);
        scan("left_edge", 2'b01, 1'b0, 1'b0);

        set_liz(620, 150, 3, 1'b1);
        scan("right_edge", 2'b10, 1'b0, 1'b0);
        chk("re_a0", 32'(a0), 32'd99);

        set_liz(200, 470, 3, 1'b1);
        scan("row_clamp", 2'b00, 1'b0, 1'b0);
        chk("rc_a0", 32'(a0), 32'd287);
        chk("rc_a1", 32'(a1), 32'd287);

        set_liz(200, 150, 3, 1'b1);
        set_ply(205, 150, 1'b0);
        scan("side", EMPTY_R, 1'b0, 1'b1);
        set_ply(232, 150, 1'b0);
        scan("no_touch", EMPTY_R, 1'b0, 1'b0);
        set_ply(231, 150, 1'b0);
        scan("edge_touch", EMPTY_R, 1'b0, 1'b1);
        set_ply(205, 127, 1'b1);
        scan("stomp_miss", EMPTY_R, 1'b0, 1'b1);

        map = '1; map[87] = 1'b0; map[107] = 1'b0;
        set_ply(500, 400, 1'b0);
        scan("ledge", LEDGE_R, 1'b0, 1'b0);

        map = '0; map[87] = 1'b1;
        set_liz(200, 150, 0, 1'b1);
        set_ply(205, 125, 1'b1);
        scan("speed0", 2'b00, 1'b0, 1'b0);

        map = '0;
        set_liz(200, 150, 3, 1'b1);
        scan("stomp", EMPTY_R, 1'b1, 1'b0);
        map[87] = 1'b1;
        scan("dead", 2'b00, 1'b0, 1'b0);

        // second tick during a scan is dropped
        do_reset();
        set_ply(500, 400, 1'b0);
        @(negedge sim_clk) tick = 1'b1;
        @(posedge sim_clk); #1 tick = 1'b0;
        @(posedge sim_clk);
        @(negedge sim_clk) tick = 1'b1;
        @(posedge sim_clk); #1 tick = 1'b0;
        for (int e = 3; e <= LAT; e++) @(posedge sim_clk);
        #1 chk("ign_col", 32'(lizardCol), 32'd2);
        acc = 1'b0;
        repeat (LAT + 2) begin
            @(posedge sim_clk); #1;
            acc |= busy | (|lizardCol) | lizardKillCol | player_hit;
        end
        chk("ign_quiet", 32'(acc), 32'd0);

        // reset mid-scan aborts
        @(negedge sim_clk) tick = 1'b1;
        @(posedge sim_clk); #1 tick = 1'b0;
        repeat (2) @(posedge sim_clk);
        #1 reset = 1'b0;
        #1 chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(tile_addr), 32'd0);
        @(negedge sim_clk) reset = 1'b1;
        acc = 1'b0;
        repeat (LAT + 2) begin
            @(posedge sim_clk); #1;
            acc |= busy | (|lizardCol) | lizardKillCol | player_hit;
        end
        chk("abort_quiet", 32'(acc), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
